// File: rtl/mem_access_unit.sv
// Load/store unit: decodes, aligns and runs one bus transaction per request.
// Sign/zero-extends loads and faults on bad, misaligned or timed-out accesses.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [5:0]    op_q;
    logic [1:0]    lane_q;

    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        aligned;
    logic        req_ok;
    logic        req_bad;
    logic        ack_hit;
    logic        tmo;
    logic [3:0]  be_nx;
    logic [31:0] wd_nx;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        unique case (opcode)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase
    end

    assign aligned = !(is_half && addr[0]) && !(is_word && (addr[1:0] != 2'b00));
    assign req_ok  = (mem_read ^ mem_write) && aligned &&
                     (mem_read ? is_load : is_store);
    assign req_bad = (mem_read || mem_write) && !req_ok;
    assign ack_hit = (state == BUSY) && bus_ack;
    assign tmo     = (state == BUSY) && !bus_ack &&
                     (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        be_nx = 4'b1111;
        wd_nx = 32'h0;
        if (is_store) begin
            if (is_word) begin
                wd_nx = wdata;
            end else if (is_half) begin
                be_nx = addr[1] ? 4'b1100 : 4'b0011;
                wd_nx = {2{wdata[15:0]}};
            end else begin
                be_nx = 4'b0001 << addr[1:0];
                wd_nx = {4{wdata[7:0]}};
            end
        end
    end

    always_comb begin
        ld_byte = bus_rdata[7:0];
        unique case (lane_q)
            2'd0: ld_byte = bus_rdata[7:0];
            2'd1: ld_byte = bus_rdata[15:8];
            2'd2: ld_byte = bus_rdata[23:16];
            2'd3: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_data = bus_rdata;
        unique case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_ok) state_nx = BUSY;
            BUSY:    if (ack_hit || tmo) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Gated by rst_n so a request held during reset never stalls the pipe
    assign stall = rst_n &&
                   (((state == IDLE) && req_ok) || (state == BUSY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            rdata     <= 32'h0;
            fault     <= 1'b0;
            cnt       <= '0;
            op_q      <= 6'h0;
            lane_q    <= 2'b00;
        end else begin
            fault <= 1'b0;
            if (state == IDLE) begin
                fault <= req_bad;
                if (req_ok) begin
                    bus_req   <= 1'b1;
                    bus_we    <= mem_write;
                    bus_addr  <= {addr[31:2], 2'b00};
                    bus_be    <= be_nx;
                    bus_wdata <= wd_nx;
                    op_q      <= opcode;
                    lane_q    <= addr[1:0];
                    cnt       <= '0;
                end
            end else if (state == BUSY) begin
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    if (!bus_we) rdata <= ld_data;
                end else if (tmo) begin
                    bus_req <= 1'b0;
                    rdata   <= 32'h0;
                    fault   <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus timeout,
// stray-ack and mid-transaction reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          dly;
        logic        bad;
        logic        we;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs[16];

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_we"}, 32'(bus_we), 32'd0);
        chk({tag, "_addr"}, bus_addr, 32'h0);
        chk({tag, "_be"}, 32'(bus_be), 32'h0);
        chk({tag, "_wdata"}, bus_wdata, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        logic [31:0] waddr;
        waddr = {v.addr[31:2], 2'b00};
        @(posedge clk); #1;
        mem_read  = v.rd;
        mem_write = v.wr;
        opcode    = v.op;
        addr      = v.addr;
        wdata     = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d_req_stall", n), 32'(stall), 32'(!v.bad));
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (v.bad) begin
            @(negedge clk);
            chk($sformatf("v%0d_fault", n), 32'(fault), 32'd1);
            chk($sformatf("v%0d_bad_req", n), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d_bad_stall", n), 32'(stall), 32'd0);
            chk($sformatf("v%0d_bad_rdata", n), rdata, v.rdat);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_fault_end", n), 32'(fault), 32'd0);
        end else begin
            for (int i = 0; i <= v.dly; i++) begin
                @(negedge clk);
                chk($sformatf("v%0d_busy_stall", n), 32'(stall), 32'd1);
                chk($sformatf("v%0d_busy_req", n), 32'(bus_req), 32'd1);
                chk($sformatf("v%0d_busy_we", n), 32'(bus_we), 32'(v.we));
                chk($sformatf("v%0d_busy_be", n), 32'(bus_be), 32'(v.be));
                chk($sformatf("v%0d_busy_wdata", n), bus_wdata, v.bwd);
                chk($sformatf("v%0d_busy_addr", n), bus_addr, waddr);
                if (i == v.dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.brd;
                end
                @(posedge clk); #1;
                bus_ack   = 1'b0;
                bus_rdata = 32'hA5A5_5A5A;
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_stall", n), 32'(stall), 32'd0);
            chk($sformatf("v%0d_done_req", n), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d_done_fault", n), 32'(fault), 32'd0);
            chk($sformatf("v%0d_done_rdata", n), rdata, v.rdat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 0, LB,  32'h103, 32'h0, 32'h80FF_1234, 1, 0, 0, 4'hF, 32'h0, 32'hFFFF_FF80};
        vecs[1]  = '{1, 0, LHU, 32'h202, 32'h0, 32'h9ABC_0000, 0, 0, 0, 4'hF, 32'h0, 32'h0000_9ABC};
        vecs[2]  = '{0, 1, SH,  32'h06, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 0, 1, 4'hC, 32'hBEEF_BEEF, 32'h0000_9ABC};
        vecs[3]  = '{1, 0, LH,  32'h00, 32'h0, 32'h1234_8001, 0, 0, 0, 4'hF, 32'h0, 32'hFFFF_8001};
        vecs[4]  = '{1, 0, LBU, 32'h01, 32'h0, 32'h0000_F000, 1, 0, 0, 4'hF, 32'h0, 32'h0000_00F0};
        vecs[5]  = '{1, 0, LW,  32'h08, 32'h0, 32'hCAFE_BABE, 0, 0, 0, 4'hF, 32'h0, 32'hCAFE_BABE};
        vecs[6]  = '{0, 1, SB,  32'h05, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 0, 1, 4'h2, 32'hA5A5_A5A5, 32'hCAFE_BABE};
        vecs[7]  = '{0, 1, SW,  32'h10, 32'h0102_0304, 32'hFFFF_FFFF, 1, 0, 1, 4'hF, 32'h0102_0304, 32'hCAFE_BABE};
        vecs[8]  = '{1, 0, LW,  32'h0A, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_BABE};
        vecs[9]  = '{1, 0, LH,  32'h03, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_BABE};
        vecs[10] = '{0, 1, LW,  32'h00, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_BABE};
        vecs[11] = '{1, 0, 6'h3F, 32'h00, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_BABE};
        vecs[12] = '{1, 1, LW,  32'h00, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_BABE};
        vecs[13] = '{1, 0, SB,  32'h00, 32'h0, 32'h0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFE_BABE};
        vecs[14] = '{1, 0, LB,  32'h02, 32'h0, 32'h007F_0000, 0, 0, 0, 4'hF, 32'h0, 32'h0000_007F};
        vecs[15] = '{0, 1, SH,  32'h00, 32'h0000_1357, 32'hFFFF_FFFF, 0, 0, 1, 4'h3, 32'h1357_1357, 32'h0000_007F};

        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        opcode    = 6'h0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
        #3;
        chk_idle_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("post_reset");

        for (int k = 0; k < 16; k++) run_vec(k, vecs[k]);

        // Timeout: LW with no ack
        @(posedge clk); #1;
        mem_read = 1'b1;
        opcode   = LW;
        addr     = 32'h20;
        @(negedge clk);
        chk("tmo_req_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tmo_busy%0d_req", i), 32'(bus_req), 32'd1);
            chk($sformatf("tmo_busy%0d_stall", i), 32'(stall), 32'd1);
            chk($sformatf("tmo_busy%0d_fault", i), 32'(fault), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_done_req", 32'(bus_req), 32'd0);
        chk("tmo_done_fault", 32'(fault), 32'd1);
        chk("tmo_done_rdata", rdata, 32'h0);
        chk("tmo_done_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("tmo_idle_fault", 32'(fault), 32'd0);
        chk("tmo_idle_req", 32'(bus_req), 32'd0);

        // Stray ack while idle
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_rdata", rdata, 32'h0);
        chk("stray_req", 32'(bus_req), 32'd0);
        chk("stray_stall", 32'(stall), 32'd0);

        // Load a nonzero result so reset clearing rdata is visible
        run_vec(16, '{1, 0, LW, 32'h30, 32'h0, 32'h1122_3344, 0, 0, 0, 4'hF, 32'h0, 32'h1122_3344});

        // Reset in the middle of a transaction, then a late ack
        @(posedge clk); #1;
        mem_read = 1'b1;
        opcode   = LW;
        addr     = 32'h44;
        @(posedge clk); #1;
        addr = 32'h0;
        @(negedge clk);
        chk("mid_busy_req", 32'(bus_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_idle_zero("mid_reset");
        @(posedge clk); #1;
        chk_idle_zero("mid_reset_held");
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk_idle_zero("late_ack");

        run_vec(17, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
